// File: rtl/dram_path_initiator.sv
// DDR3 user-interface requester: one burst request in, command/data beats out.
// Optional outstanding-read cap enabled by defining DRAM_OUTSTD_LIMIT_EN.
module dram_path_initiator #(
  parameter int DDRAWidth  = 28,
  parameter int DDRDWidth  = 512,
  parameter int DDRCWidth  = 3,
  parameter int BWidth     = 7,
  parameter int AddrStride = 8,
  parameter int MaxOutstd  = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DDRAWidth-1:0] ReqAddress,
  input  logic                 ReqWrite,
  input  logic [BWidth-1:0]    ReqBeats,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic [DDRDWidth-1:0] WrData,
  input  logic                 WrDataValid,
  output logic                 WrDataReady,
  output logic [DDRDWidth-1:0] RdData,
  output logic                 RdDataValid,
  output logic                 Done,
  output logic [DDRAWidth-1:0] DRAMAddress,
  output logic [DDRCWidth-1:0] DRAMCommand,
  output logic                 DRAMCommandValid,
  input  logic                 DRAMCommandReady,
  output logic [DDRDWidth-1:0] DRAMWriteData,
  output logic                 DRAMWriteDataValid,
  input  logic                 DRAMWriteDataReady,
  input  logic [DDRDWidth-1:0] DRAMReadData,
  input  logic                 DRAMReadDataValid
);

  localparam logic [DDRCWidth-1:0] CmdWrite = DDRCWidth'(0);
  localparam logic [DDRCWidth-1:0] CmdRead  = DDRCWidth'(1);
  localparam logic [DDRAWidth-1:0] Stride   = DDRAWidth'(AddrStride);

  typedef enum logic [2:0] {
    IDLE, RD_CMD, RD_WAIT, WR, DONE
  } state_t;

  state_t state, state_nx;

  logic [DDRAWidth-1:0] addr;
  logic [DDRCWidth-1:0] cmd;
  logic [BWidth-1:0]    beats;
  logic [BWidth-1:0]    beat_cnt;
  logic [BWidth-1:0]    ret_cnt;
  logic                 cmd_sent;
  logic                 data_sent;

  logic                 rd_active;
  logic                 issue_ok;
  logic                 cmd_fire;
  logic                 wd_fire;
  logic                 beat_done;
  logic                 last_beat;
  logic [BWidth:0]      ret_total;

`ifdef DRAM_OUTSTD_LIMIT_EN
  logic [BWidth-1:0] outstd;
  assign outstd   = beat_cnt - ret_cnt;
  assign issue_ok = int'(outstd) < MaxOutstd;
`else
  assign issue_ok = 1'b1;
`endif

  assign rd_active = (state == RD_CMD) || (state == RD_WAIT);
  assign last_beat = (beat_cnt + BWidth'(1)) == beats;
  assign ret_total = {1'b0, ret_cnt} + (BWidth+1)'(DRAMReadDataValid);

  assign ReqReady    = (state == IDLE);
  assign Done        = (state == DONE);
  assign RdData      = DRAMReadData;
  assign RdDataValid = DRAMReadDataValid & rd_active;

  assign DRAMAddress   = addr;
  assign DRAMCommand   = cmd;
  assign DRAMWriteData = WrData;

  // Once the data half of a beat is gone the command may still finish alone.
  assign DRAMCommandValid =
    ((state == RD_CMD) & issue_ok) |
    ((state == WR) & ~cmd_sent & (WrDataValid | data_sent));
  assign DRAMWriteDataValid = (state == WR) & WrDataValid & ~data_sent;
  assign WrDataReady = (state == WR) & DRAMWriteDataReady & ~data_sent;

  assign cmd_fire  = DRAMCommandValid & DRAMCommandReady;
  assign wd_fire   = DRAMWriteDataValid & DRAMWriteDataReady;
  assign beat_done = (cmd_sent | cmd_fire) & (data_sent | wd_fire);

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (ReqValid) begin
          if (ReqBeats == '0) state_nx = DONE;
          else if (ReqWrite)  state_nx = WR;
          else                state_nx = RD_CMD;
        end
      end
      RD_CMD: begin
        if (cmd_fire && last_beat) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (ret_total >= {1'b0, beats}) state_nx = DONE;
      end
      WR: begin
        if (beat_done && last_beat) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Burst datapath: address, beat/return counters, per-beat sent flags
  always_ff @(posedge Clock) begin
    if (Reset) begin
      addr      <= '0;
      cmd       <= CmdRead;
      beats     <= '0;
      beat_cnt  <= '0;
      ret_cnt   <= '0;
      cmd_sent  <= 1'b0;
      data_sent <= 1'b0;
    end else begin
      if (state == IDLE && ReqValid) begin
        addr      <= ReqAddress;
        cmd       <= ReqWrite ? CmdWrite : CmdRead;
        beats     <= ReqBeats;
        beat_cnt  <= '0;
        ret_cnt   <= '0;
        cmd_sent  <= 1'b0;
        data_sent <= 1'b0;
      end
      if (rd_active && DRAMReadDataValid) begin
        ret_cnt <= ret_cnt + BWidth'(1);
      end
      if (state == RD_CMD && cmd_fire) begin
        addr     <= addr + Stride;
        beat_cnt <= beat_cnt + BWidth'(1);
      end
      if (state == WR) begin
        if (beat_done) begin
          cmd_sent  <= 1'b0;
          data_sent <= 1'b0;
          addr      <= addr + Stride;
          beat_cnt  <= beat_cnt + BWidth'(1);
        end else begin
          if (cmd_fire) cmd_sent  <= 1'b1;
          if (wd_fire)  data_sent <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_path_initiator.sv
// Randomized bench for dram_path_initiator with a DRAM responder model
// and per-burst expected address/data sequences.
module tb_dram_path_initiator;

  localparam int AW  = 28;
  localparam int DW  = 512;
  localparam int CW  = 3;
  localparam int BW  = 7;
  localparam int LIM = 16;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [AW-1:0] ReqAddress;
  logic          ReqWrite;
  logic [BW-1:0] ReqBeats;
  logic          ReqValid;
  logic          ReqReady;
  logic [DW-1:0] WrData;
  logic          WrDataValid;
  logic          WrDataReady;
  logic [DW-1:0] RdData;
  logic          RdDataValid;
  logic          Done;
  logic [AW-1:0] DRAMAddress;
  logic [CW-1:0] DRAMCommand;
  logic          DRAMCommandValid;
  logic          DRAMCommandReady;
  logic [DW-1:0] DRAMWriteData;
  logic          DRAMWriteDataValid;
  logic          DRAMWriteDataReady;
  logic [DW-1:0] DRAMReadData;
  logic          DRAMReadDataValid;

  always #5 Clock = ~Clock;

  dram_path_initiator dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .ReqAddress         (ReqAddress),
    .ReqWrite           (ReqWrite),
    .ReqBeats           (ReqBeats),
    .ReqValid           (ReqValid),
    .ReqReady           (ReqReady),
    .WrData             (WrData),
    .WrDataValid        (WrDataValid),
    .WrDataReady        (WrDataReady),
    .RdData             (RdData),
    .RdDataValid        (RdDataValid),
    .Done               (Done),
    .DRAMAddress        (DRAMAddress),
    .DRAMCommand        (DRAMCommand),
    .DRAMCommandValid   (DRAMCommandValid),
    .DRAMCommandReady   (DRAMCommandReady),
    .DRAMWriteData      (DRAMWriteData),
    .DRAMWriteDataValid (DRAMWriteDataValid),
    .DRAMWriteDataReady (DRAMWriteDataReady),
    .DRAMReadData       (DRAMReadData),
    .DRAMReadDataValid  (DRAMReadDataValid)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit            rst_req;
  bit            req_pend;
  bit            directed;
  bit            wfire;
  int            lat;
  int            stall_left;
  int            inflight;
  int            max_inflight;
  int            acc_cyc;
  int            done_cyc;
  int            last_rd_cyc;
  int            done_cnt;
  int            widx;
  logic [AW-1:0] obs_addr[$];
  logic [CW-1:0] obs_cmd[$];
  logic [DW-1:0] obs_wd[$];
  logic [DW-1:0] obs_rd[$];
  logic [DW-1:0] wbeat[$];
  int            ret_due[$];
  logic [DW-1:0] ret_dat[$];

  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = {a, 4'(i)};
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive();
    Reset = rst_req;
    ReqValid = req_pend;
    DRAMCommandReady = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (directed)
      DRAMWriteDataReady = !(obs_wd.size() == 1 && stall_left > 0);
    else
      DRAMWriteDataReady = ($urandom_range(0, 2) != 0);
    if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
      DRAMReadDataValid = 1'b1;
      DRAMReadData = ret_dat[0];
      void'(ret_due.pop_front());
      void'(ret_dat.pop_front());
      inflight--;
    end else begin
      DRAMReadDataValid = 1'b0;
      DRAMReadData = '0;
    end
    if (wfire) begin
      widx++;
      WrDataValid = 1'b0;
      wfire = 1'b0;
    end
    if (widx < wbeat.size()) begin
      if (!WrDataValid)
        WrDataValid = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
      WrData = wbeat[widx];
    end else begin
      WrDataValid = 1'b0;
    end
  endtask

  task automatic sample();
    if (ReqValid && ReqReady) begin
      req_pend = 1'b0;
      acc_cyc = cyc;
    end
    if (DRAMCommandValid && DRAMCommandReady) begin
      obs_addr.push_back(DRAMAddress);
      obs_cmd.push_back(DRAMCommand);
      if (DRAMCommand == 3'b001) begin
        ret_due.push_back(cyc + lat);
        ret_dat.push_back(rd_pat(DRAMAddress));
        inflight++;
        if (inflight > max_inflight) max_inflight = inflight;
      end
    end
    if (DRAMWriteDataValid && DRAMWriteDataReady)
      obs_wd.push_back(DRAMWriteData);
    if (directed && !DRAMWriteDataReady && obs_wd.size() == 1 && stall_left > 0)
      stall_left--;
    if (RdDataValid) begin
      obs_rd.push_back(RdData);
      last_rd_cyc = cyc;
    end
    if (Done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (WrDataValid && WrDataReady) wfire = 1'b1;
  endtask

  task automatic step();
    @(negedge Clock);
    cyc++;
    drive();
    #1;
    sample();
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_cmd.delete();
    obs_wd.delete();
    obs_rd.delete();
    wbeat.delete();
    done_cnt = 0;
    widx = 0;
    wfire = 1'b0;
    max_inflight = 0;
    stall_left = 2;
  endtask

  task automatic run_req(input logic [AW-1:0] base, input bit wr,
                         input int beats, input int l, input bit dir);
    int n;
    logic [AW-1:0] ea;
    clear_obs();
    lat = l;
    directed = dir;
    for (int i = 0; i < beats; i++) if (wr) wbeat.push_back(rand_beat());
    ReqAddress = base;
    ReqWrite = wr;
    ReqBeats = BW'(beats);
    req_pend = 1'b1;
    n = 0;
    while ((done_cnt == 0 || ret_due.size() != 0) && n < 3000) begin
      step();
      n++;
    end
    for (int i = 0; i < 3; i++) step();
    chk("no_timeout", DW'(n < 3000), DW'(1));
    chk("n_cmd", DW'(obs_addr.size()), DW'(beats));
    for (int i = 0; i < obs_addr.size() && i < beats; i++) begin
      ea = base + AW'(i * 8);
      chk("cmd_addr", DW'(obs_addr[i]), DW'(ea));
      chk("cmd_type", DW'(obs_cmd[i]), DW'(wr ? 0 : 1));
    end
    if (wr) begin
      chk("n_wdata", DW'(obs_wd.size()), DW'(beats));
      for (int i = 0; i < obs_wd.size() && i < beats; i++)
        chk("wdata", obs_wd[i], wbeat[i]);
      chk("n_rdata", DW'(obs_rd.size()), DW'(0));
    end else begin
      chk("n_rdata", DW'(obs_rd.size()), DW'(beats));
      for (int i = 0; i < obs_rd.size() && i < beats; i++) begin
        ea = base + AW'(i * 8);
        chk("rdata", obs_rd[i], rd_pat(ea));
      end
      chk("n_wdata", DW'(obs_wd.size()), DW'(0));
    end
    chk("done_cnt", DW'(done_cnt), DW'(1));
    if (beats == 0)
      chk("done_lat_zero", DW'(done_cyc - acc_cyc), DW'(1));
    else if (!wr)
      chk("done_after_rd", DW'(done_cyc - last_rd_cyc), DW'(1));
`ifdef DRAM_OUTSTD_LIMIT_EN
    if (!wr) chk("outstd_cap", DW'(max_inflight <= LIM), DW'(1));
`endif
    if (n >= 3000) begin
      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
      ret_due.delete();
      ret_dat.delete();
      inflight = 0;
    end
  endtask

  task automatic reset_mid_burst();
    int n;
    clear_obs();
    lat = 25;
    directed = 1'b1;
    ReqAddress = 28'h0000400;
    ReqWrite = 1'b0;
    ReqBeats = BW'(2);
    req_pend = 1'b1;
    n = 0;
    while (obs_addr.size() < 2 && n < 100) begin
      step();
      n++;
    end
    step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    chk("midrst_reqready", DW'(ReqReady), DW'(1));
    chk("midrst_cmdvalid", DW'(DRAMCommandValid), DW'(0));
    n = 0;
    while (ret_due.size() != 0 && n < 200) begin
      step();
      n++;
    end
    step();
    chk("midrst_drops", DW'(obs_rd.size()), DW'(0));
    chk("midrst_done", DW'(done_cnt), DW'(0));
    chk("midrst_ncmd", DW'(obs_addr.size()), DW'(2));
  endtask

  initial begin
    Reset = 1'b1;
    ReqAddress = '0;
    ReqWrite = 1'b0;
    ReqBeats = '0;
    ReqValid = 1'b0;
    WrData = '0;
    WrDataValid = 1'b0;
    DRAMCommandReady = 1'b0;
    DRAMWriteDataReady = 1'b0;
    DRAMReadData = '0;
    DRAMReadDataValid = 1'b0;
    rst_req = 1'b1;
    req_pend = 1'b0;
    directed = 1'b1;
    inflight = 0;
    lat = 1;
    clear_obs();

    for (int i = 0; i < 3; i++) step();
    rst_req = 1'b0;
    step();
    chk("rst_reqready", DW'(ReqReady), DW'(1));
    chk("rst_cmdvalid", DW'(DRAMCommandValid), DW'(0));
    chk("rst_wdvalid", DW'(DRAMWriteDataValid), DW'(0));
    chk("rst_rdvalid", DW'(RdDataValid), DW'(0));
    chk("rst_done", DW'(Done), DW'(0));

    run_req(28'h0000100, 1'b0, 4, 25, 1'b1);
    run_req(28'h0002000, 1'b1, 3, 5, 1'b1);
    chk("wr_stall_used", DW'(stall_left), DW'(0));
    run_req(28'h0000040, 1'b0, 0, 5, 1'b1);
    run_req(28'h0000040, 1'b1, 0, 5, 1'b1);
    run_req(28'hFFFFFF8, 1'b0, 2, 10, 1'b1);
    run_req(28'hFFFFFF0, 1'b1, 4, 10, 1'b0);
    reset_mid_burst();
    run_req(28'h0000300, 1'b0, 20, 25, 1'b1);

    for (int t = 0; t < 12; t++) begin
      run_req(AW'($urandom), 1'(($urandom_range(0, 1))),
              $urandom_range(0, 12), $urandom_range(1, 30), 1'b0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
